// File: rtl/instx_encoder_loader_pkg.sv
// Shared LEGv8 encoding constants for the instruction loader: op select codes,
// 11-bit opcodes (same values the control decoder compares), field widths, loader states.
package instx_encoder_loader_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_AND    = 4'd2,
        OP_ORR    = 4'd3,
        OP_EOR    = 4'd4,
        OP_LSL    = 4'd5,
        OP_LDURSW = 4'd6,
        OP_STURW  = 4'd7,
        OP_B      = 4'd8,
        OP_BR     = 4'd9,
        OP_BGT    = 4'd10,
        OP_ADDI   = 4'd11,
        OP_NOP    = 4'd12
    } op_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FULL  = 2'd2
    } ld_state_e;

    localparam logic [10:0] OPC_ADD    = 11'h458;
    localparam logic [10:0] OPC_SUB    = 11'h658;
    localparam logic [10:0] OPC_AND    = 11'h450;
    localparam logic [10:0] OPC_ORR    = 11'h550;
    localparam logic [10:0] OPC_EOR    = 11'h650;
    localparam logic [10:0] OPC_LSL    = 11'h69B;
    localparam logic [10:0] OPC_BR     = 11'h6B0;
    localparam logic [10:0] OPC_LDURSW = 11'h5C4;
    localparam logic [10:0] OPC_STURW  = 11'h5C0;
    localparam logic [9:0]  OPC_ADDI   = 10'h244;
    localparam logic [5:0]  OPC_B      = 6'h05;
    localparam logic [7:0]  OPC_BGT    = 8'h54;
    localparam logic [4:0]  BGT_COND   = 5'h0C;

    localparam int IMM_I_W  = 12;
    localparam int IMM_D_W  = 9;
    localparam int IMM_CB_W = 19;
    localparam int IMM_B_W  = 26;

endpackage

// File: rtl/instx_field_pack.sv
// Combinational packer: op select + register/immediate fields -> 32-bit LEGv8 word.
// Optional ENC_RANGE_CHECK_EN flags immediates that do not fit their field instead of truncating.
module instx_field_pack
    import instx_encoder_loader_pkg::*;
(
    input  logic [3:0]  i_op_sel,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rn,
    input  logic [4:0]  i_rm,
    input  logic [5:0]  i_shamt,
    input  logic [25:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_bad
);

`ifdef ENC_RANGE_CHECK_EN
    // True when bits above the field all replicate the field's sign bit.
    function automatic logic sext_fits(input logic [25:0] v, input int w);
        logic ok;
        ok = 1'b1;
        for (int i = w; i < 26; i++) begin
            if (v[i] != v[w-1]) ok = 1'b0;
        end
        return ok;
    endfunction
`endif

    always_comb begin
        o_word = 32'h0;
        o_bad  = 1'b0;
        case (i_op_sel)
            OP_ADD:    o_word = {OPC_ADD, i_rm, 6'd0, i_rn, i_rd};
            OP_SUB:    o_word = {OPC_SUB, i_rm, 6'd0, i_rn, i_rd};
            OP_AND:    o_word = {OPC_AND, i_rm, 6'd0, i_rn, i_rd};
            OP_ORR:    o_word = {OPC_ORR, i_rm, 6'd0, i_rn, i_rd};
            OP_EOR:    o_word = {OPC_EOR, i_rm, 6'd0, i_rn, i_rd};
            OP_LSL:    o_word = {OPC_LSL, i_rm, i_shamt, i_rn, i_rd};
            OP_BR:     o_word = {OPC_BR, 5'd0, 6'd0, i_rn, 5'd0};
            OP_LDURSW: o_word = {OPC_LDURSW, i_imm[IMM_D_W-1:0], 2'b00, i_rn, i_rd};
            OP_STURW:  o_word = {OPC_STURW, i_imm[IMM_D_W-1:0], 2'b00, i_rn, i_rd};
            OP_B:      o_word = {OPC_B, i_imm[IMM_B_W-1:0]};
            OP_BGT:    o_word = {OPC_BGT, i_imm[IMM_CB_W-1:0], BGT_COND};
            OP_ADDI:   o_word = {OPC_ADDI, i_imm[IMM_I_W-1:0], i_rn, i_rd};
            OP_NOP:    o_word = 32'h0;
            default:   o_bad  = 1'b1;
        endcase
`ifdef ENC_RANGE_CHECK_EN
        // Shamt is 6 bits wide so it can never exceed 63; only immediates need checking.
        case (i_op_sel)
            OP_ADDI:            if (|i_imm[25:IMM_I_W]) o_bad = 1'b1;
            OP_LDURSW, OP_STURW: if (!sext_fits(i_imm, IMM_D_W)) o_bad = 1'b1;
            OP_BGT:             if (!sext_fits(i_imm, IMM_CB_W)) o_bad = 1'b1;
            default:            ;
        endcase
`endif
    end

endmodule

// File: rtl/instx_encoder_loader.sv
// Sequential loader: accepts encode requests, writes one word per two cycles into
// instruction memory until DEPTH words are loaded. Optional feature: ENC_RANGE_CHECK_EN.
//
// state   | meaning
// IDLE    | ready for a request beat (InReady=1)
// WRITE   | memory write strobe asserted for one cycle
// FULL    | DEPTH words written, waits for Start
module instx_encoder_loader
    import instx_encoder_loader_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int DEPTH     = 64,
    parameter int BASE_ADDR = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [3:0]        i_op_sel,
    input  logic [4:0]        i_rd,
    input  logic [4:0]        i_rn,
    input  logic [4:0]        i_rm,
    input  logic [5:0]        i_shamt,
    input  logic [25:0]       i_imm,
    output logic              o_im_we,
    output logic [ADDR_W-1:0] o_im_addr,
    output logic [31:0]       o_im_data,
    output logic [ADDR_W:0]   o_count,
    output logic              o_full,
    output logic              o_done,
    output logic              o_err
);

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_M1 = DEPTH_C - 1'b1;

    ld_state_e         r_state;
    ld_state_e         w_state_nxt;
    logic              r_in_ready;
    logic              r_im_we;
    logic [ADDR_W-1:0] r_im_addr;
    logic [31:0]       r_im_data;
    logic [ADDR_W:0]   r_count;
    logic              r_done;
    logic              r_err;
    logic [31:0]       w_word;
    logic              w_bad;
    logic              w_accept;

    instx_field_pack u_field_pack (
        .i_op_sel (i_op_sel),
        .i_rd     (i_rd),
        .i_rn     (i_rn),
        .i_rm     (i_rm),
        .i_shamt  (i_shamt),
        .i_imm    (i_imm),
        .o_word   (w_word),
        .o_bad    (w_bad)
    );

    assign w_accept = i_in_valid & r_in_ready & ~i_start;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept && !w_bad) w_state_nxt = ST_WRITE;
            ST_WRITE: begin
                if (i_start)                  w_state_nxt = ST_IDLE;
                else if (r_count == DEPTH_M1) w_state_nxt = ST_FULL;
                else                          w_state_nxt = ST_IDLE;
            end
            ST_FULL:  if (i_start) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Start in WRITE arrives on the edge that ends the write, so the strobe has
    // already been issued; reinitialising here replaces the post-write increment.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_in_ready <= 1'b0;
            r_im_we    <= 1'b0;
            r_im_addr  <= BASE;
            r_im_data  <= 32'h0;
            r_count    <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_in_ready <= (w_state_nxt == ST_IDLE);
            r_im_we    <= (w_state_nxt == ST_WRITE);
            r_done     <= 1'b0;
            if (i_start) begin
                r_count   <= '0;
                r_im_addr <= BASE;
                r_err     <= 1'b0;
            end else if (r_state == ST_WRITE) begin
                r_count   <= r_count + 1'b1;
                r_im_addr <= r_im_addr + 1'b1;
            end else if (w_accept) begin
                if (w_bad) begin
                    r_err <= 1'b1;
                end else begin
                    r_im_data <= w_word;
                    r_done    <= (r_count == DEPTH_M1);
                end
            end
        end
    end

    assign o_in_ready = r_in_ready;
    assign o_im_we    = r_im_we;
    assign o_im_addr  = r_im_addr;
    assign o_im_data  = r_im_data;
    assign o_count    = r_count;
    assign o_full     = (r_count == DEPTH_C);
    assign o_done     = r_done;
    assign o_err      = r_err;

endmodule

// File: tb/tb_instx_encoder_loader.sv
// Directed bench for instx_encoder_loader (DEPTH=4): scoreboard of expected memory writes.
module tb_instx_encoder_loader;

    logic        clk;
    logic        rst_n;
    logic        i_start;
    logic        i_in_valid;
    logic        o_in_ready;
    logic [3:0]  i_op_sel;
    logic [4:0]  i_rd, i_rn, i_rm;
    logic [5:0]  i_shamt;
    logic [25:0] i_imm;
    logic        o_im_we;
    logic [5:0]  o_im_addr;
    logic [31:0] o_im_data;
    logic [6:0]  o_count;
    logic        o_full, o_done, o_err;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } sb_t;

    sb_t        sb[$];
    int         checks = 0;
    int         failures = 0;
    int         n_writes = 0;
    int         n_done = 0;
    int         done_at = -1;
    logic [5:0] exp_addr = 6'd0;

    instx_encoder_loader #(.ADDR_W(6), .DEPTH(4), .BASE_ADDR(0)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (i_start),
        .i_in_valid (i_in_valid),
        .o_in_ready (o_in_ready),
        .i_op_sel   (i_op_sel),
        .i_rd       (i_rd),
        .i_rn       (i_rn),
        .i_rm       (i_rm),
        .i_shamt    (i_shamt),
        .i_imm      (i_imm),
        .o_im_we    (o_im_we),
        .o_im_addr  (o_im_addr),
        .o_im_data  (o_im_data),
        .o_count    (o_count),
        .o_full     (o_full),
        .o_done     (o_done),
        .o_err      (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && o_done) n_done++;
        if (rst_n && o_im_we) begin
            sb_t e;
            n_writes++;
            if (o_done) done_at = n_writes;
            check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("wr_addr", 32'(o_im_addr), 32'(e.addr));
                check("wr_data", o_im_data, e.data);
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                        input logic [4:0] rm, input logic [5:0] sh, input logic [25:0] imm,
                        input logic wr, input logic [31:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (!o_in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", 32'(o_in_ready), 32'd1);
        i_op_sel = op; i_rd = rd; i_rn = rn; i_rm = rm; i_shamt = sh; i_imm = imm;
        i_in_valid = 1'b1;
        if (wr) begin
            sb.push_back('{addr: exp_addr, data: d});
            exp_addr = exp_addr + 6'd1;
        end
        @(posedge clk);
        #1 i_in_valid = 1'b0;
        @(negedge clk);
        check("we_after_accept", 32'(o_im_we), 32'(wr));
    endtask

    task automatic do_start();
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        exp_addr = 6'd0;
    endtask

    initial begin
        int base_w, base_d;
        rst_n = 1'b0; i_start = 1'b0; i_in_valid = 1'b0;
        i_op_sel = 4'd0; i_rd = 5'd0; i_rn = 5'd0; i_rm = 5'd0; i_shamt = 6'd0; i_imm = 26'd0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(o_in_ready), 32'd0);
        check("rst_we", 32'(o_im_we), 32'd0);
        check("rst_addr", 32'(o_im_addr), 32'd0);
        check("rst_data", o_im_data, 32'd0);
        check("rst_count", 32'(o_count), 32'd0);
        check("rst_flags", {29'd0, o_full, o_done, o_err}, 32'd0);
        rst_n = 1'b1;
        #1 check("ready_low_at_release", 32'(o_in_ready), 32'd0);
        @(negedge clk);
        check("ready_after_release", 32'(o_in_ready), 32'd1);

        send(4'd0, 5'd3, 5'd1, 5'd2, 6'd0, 26'd0, 1'b1, 32'h8B02_0023);
        @(negedge clk);
        check("count_add", 32'(o_count), 32'd1);
        do_start();
        check("count_start", 32'(o_count), 32'd0);

        send(4'd11, 5'd1, 5'd31, 5'd0, 6'd0, 26'd5, 1'b1, 32'h9100_17E1);
        send(4'd6, 5'd2, 5'd1, 5'd0, 6'd0, 26'd4, 1'b1, 32'hB880_4022);
        @(negedge clk);
        check("count_two", 32'(o_count), 32'd2);
        do_start();

        send(4'd8, 5'd0, 5'd0, 5'd0, 6'd0, 26'h3FF_FFFF, 1'b1, 32'h17FF_FFFF);
        send(4'd10, 5'd0, 5'd0, 5'd0, 6'd0, 26'd2, 1'b1, 32'h5400_004C);
        send(4'd12, 5'd9, 5'd9, 5'd9, 6'd9, 26'd9, 1'b1, 32'h0000_0000);
        do_start();

        send(4'd5, 5'd4, 5'd2, 5'd0, 6'd3, 26'd0, 1'b1, 32'hD360_0C44);
        send(4'd9, 5'd7, 5'd30, 5'd5, 6'd0, 26'd0, 1'b1, 32'hD600_03C0);
        send(4'd7, 5'd3, 5'd4, 5'd0, 6'd0, 26'h3FF_FFFE, 1'b1, 32'hB81F_E083);
        do_start();

        send(4'd14, 5'd1, 5'd1, 5'd1, 6'd0, 26'd0, 1'b0, 32'h0);
        check("err_illegal", 32'(o_err), 32'd1);
        check("count_illegal", 32'(o_count), 32'd0);
        send(4'd0, 5'd3, 5'd1, 5'd2, 6'd0, 26'd0, 1'b1, 32'h8B02_0023);
        @(negedge clk);
        check("err_sticky", 32'(o_err), 32'd1);
        do_start();
        check("err_cleared", 32'(o_err), 32'd0);

`ifdef ENC_RANGE_CHECK_EN
        send(4'd11, 5'd1, 5'd31, 5'd0, 6'd0, 26'd4096, 1'b0, 32'h0);
        check("err_range", 32'(o_err), 32'd1);
        check("count_range", 32'(o_count), 32'd0);
`else
        send(4'd11, 5'd1, 5'd31, 5'd0, 6'd0, 26'd4096, 1'b1, 32'h9100_03E1);
        @(negedge clk);
        check("err_trunc", 32'(o_err), 32'd0);
        check("count_trunc", 32'(o_count), 32'd1);
`endif
        do_start();

        base_w = n_writes;
        base_d = n_done;
        for (int i = 0; i < 4; i++) sb.push_back('{addr: 6'(i), data: 32'hAA07_00C5});
        @(negedge clk);
        i_op_sel = 4'd3; i_rd = 5'd5; i_rn = 5'd6; i_rm = 5'd7; i_shamt = 6'd0; i_imm = 26'd0;
        i_in_valid = 1'b1;
        repeat (12) @(negedge clk);
        check("full_writes", 32'(n_writes - base_w), 32'd4);
        check("full_done_pulses", 32'(n_done - base_d), 32'd1);
        check("full_done_on_4th", 32'(done_at), 32'(base_w + 4));
        check("full_flag", 32'(o_full), 32'd1);
        check("full_ready", 32'(o_in_ready), 32'd0);
        check("full_count", 32'(o_count), 32'd4);
        i_in_valid = 1'b0;
        do_start();
        check("full_start_count", 32'(o_count), 32'd0);
        check("full_start_flag", 32'(o_full), 32'd0);

        send(4'd1, 5'd1, 5'd2, 5'd3, 6'd0, 26'd0, 1'b1, 32'hCB03_0041);
        @(negedge clk);
        @(negedge clk);
        i_op_sel = 4'd0; i_rd = 5'd3; i_rn = 5'd1; i_rm = 5'd2; i_in_valid = 1'b1;
        @(posedge clk);
        #1 i_in_valid = 1'b0;
        check("we_before_reset", 32'(o_im_we), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("reset_we", 32'(o_im_we), 32'd0);
        check("reset_count", 32'(o_count), 32'd0);
        check("reset_addr", 32'(o_im_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(o_in_ready), 32'd1);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
